// File: rtl/dso_trig_pkg.sv
// Shared types and constants for the scope trigger path: mode and state
// encodings, trig_cfg field positions, and the channel select helper.
package dso_trig_pkg;

    typedef enum logic [1:0] {
        OFF        = 2'b00,
        NORMAL     = 2'b01,
        AUTO       = 2'b10,
        FORCE_ONLY = 2'b11
    } trig_mode_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ARMED     = 2'b01,
        TRIGGERED = 2'b10
    } trig_state_t;

    localparam int CFG_HYST    = 5;
    localparam int CFG_EDGE    = 4;
    localparam int CFG_MODE_HI = 3;
    localparam int CFG_MODE_LO = 2;
    localparam int CFG_SRC_HI  = 1;
    localparam int CFG_SRC_LO  = 0;

    // Source code 00 falls back to channel 1 so an unprogrammed config still tracks something.
    function automatic logic [7:0] select_source(
        input logic [1:0] src,
        input logic [7:0] ch1,
        input logic [7:0] ch2,
        input logic [7:0] ch3
    );
        logic [7:0] sel;
        case (src)
            2'b10:   sel = ch2;
            2'b11:   sel = ch3;
            default: sel = ch1;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/trig_comparator.sv
// Level comparator with optional hysteresis. Tracks whether the selected
// channel is above the trigger level and reports crossings on sample strobes.
module trig_comparator
    import dso_trig_pkg::*;
#(
    parameter int HYST = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_smpl_valid,
    input  logic [7:0] i_ch1_data,
    input  logic [7:0] i_ch2_data,
    input  logic [7:0] i_ch3_data,
    input  logic [1:0] i_src,
    input  logic       i_hyst_en,
    input  logic [7:0] i_level,
    output logic       o_rise,
    output logic       o_fall
);

    logic [7:0] w_sel;
    logic [8:0] w_h;
    logic [8:0] w_level9;
    logic [8:0] w_hi_sum;
    logic [8:0] w_hi_thr;
    logic [8:0] w_lo_thr;
    logic       w_above_next;
    logic       r_above;

    assign w_sel    = select_source(i_src, i_ch1_data, i_ch2_data, i_ch3_data);
    assign w_h      = i_hyst_en ? 9'(HYST) : 9'd0;
    assign w_level9 = {1'b0, i_level};
    assign w_hi_sum = w_level9 + w_h;
    assign w_hi_thr = (w_hi_sum > 9'd255) ? 9'd255 : w_hi_sum;
    assign w_lo_thr = (w_level9 < w_h) ? 9'd0 : (w_level9 - w_h);

    // Hysteresis decision: the upper threshold is checked first so it wins when both thresholds coincide.
    always_comb begin
        w_above_next = r_above;
        if ({1'b0, w_sel} >= w_hi_thr) begin
            w_above_next = 1'b1;
        end else if ({1'b0, w_sel} < w_lo_thr) begin
            w_above_next = 1'b0;
        end
    end

    assign o_rise = i_smpl_valid &  w_above_next & ~r_above;
    assign o_fall = i_smpl_valid & ~w_above_next &  r_above;

    // The above flag moves only on valid samples, in every trigger state, so it is current when arming.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_above <= 1'b0;
        end else if (i_smpl_valid) begin
            r_above <= w_above_next;
        end
    end

endmodule

// File: rtl/trigger_logic.sv
// Trigger controller for the capture block: qualifies comparator edges,
// forced and auto-timeout triggers, and holds a sticky trigger level until
// the capture block reports completion.
module trigger_logic
    import dso_trig_pkg::*;
#(
    parameter int HYST         = 4,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       smpl_valid,
    input  logic [7:0] ch1_data,
    input  logic [7:0] ch2_data,
    input  logic [7:0] ch3_data,
    input  logic [5:0] trig_cfg,
    input  logic [7:0] trig_level,
    input  logic       armed,
    input  logic       capture_done,
    input  logic       force_trig,
    output logic       trigger,
    output logic       auto_fired,
    output logic [1:0] trig_state
);

    localparam int CNT_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_TIMEOUT - 1);

    trig_mode_t       w_mode;
    trig_state_t      r_state;
    trig_state_t      w_state_next;
    logic             r_trigger;
    logic             r_auto;
    logic             w_auto_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_rise;
    logic             w_fall;
    logic             w_qual_edge;
    logic             w_edge_mode;
    logic             w_auto_step;

    assign w_mode = trig_mode_t'(trig_cfg[CFG_MODE_HI:CFG_MODE_LO]);

    trig_comparator #(
        .HYST (HYST)
    ) u_comparator (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_smpl_valid (smpl_valid),
        .i_ch1_data   (ch1_data),
        .i_ch2_data   (ch2_data),
        .i_ch3_data   (ch3_data),
        .i_src        (trig_cfg[CFG_SRC_HI:CFG_SRC_LO]),
        .i_hyst_en    (trig_cfg[CFG_HYST]),
        .i_level      (trig_level),
        .o_rise       (w_rise),
        .o_fall       (w_fall)
    );

    assign w_qual_edge = trig_cfg[CFG_EDGE] ? w_rise : w_fall;
    assign w_edge_mode = (w_mode == NORMAL) || (w_mode == AUTO);
    assign w_auto_step = (w_mode == AUTO) && smpl_valid;

    // Next-state logic: disarm beats every trigger source, then force, qualified edge, auto timeout.
    always_comb begin
        w_state_next = r_state;
        w_auto_next  = r_auto;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (armed && (w_mode != OFF)) begin
                    w_state_next = ARMED;
                    w_cnt_next   = '0;
                end
            end
            ARMED: begin
                if (!armed || (w_mode == OFF)) begin
                    w_state_next = IDLE;
                end else if (force_trig) begin
                    w_state_next = TRIGGERED;
                    w_auto_next  = 1'b0;
                end else if (w_qual_edge && w_edge_mode) begin
                    w_state_next = TRIGGERED;
                    w_auto_next  = 1'b0;
                end else if (w_auto_step && (r_cnt == CNT_LAST)) begin
                    w_state_next = TRIGGERED;
                    w_auto_next  = 1'b1;
                end else if (w_auto_step) begin
                    w_cnt_next   = r_cnt + 1'b1;
                end
            end
            TRIGGERED: begin
                if (capture_done || (w_mode == OFF)) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, auto flag, timeout counter and the registered trigger level; reset may land mid-capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_auto    <= 1'b0;
            r_cnt     <= '0;
            r_trigger <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_auto    <= w_auto_next;
            r_cnt     <= w_cnt_next;
            r_trigger <= (w_state_next == TRIGGERED);
        end
    end

    assign trigger    = r_trigger;
    assign auto_fired = r_auto;
    assign trig_state = r_state;

endmodule
